// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, ALU codes,
// datapath mux selects, FSM states and the bundled control word.
package mc_pkg;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_LUI = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXE_R   = 4'd2,
        S_EXE_I   = 4'd3,
        S_MEM_ADR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB_ALU  = 4'd7,
        S_WB_MEM  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_wr;
        logic       ir_wr;
        logic       pc_wr;
        logic       pc_wr_cond;
        logic [1:0] pc_src;
        logic       src_a;
        logic [1:0] src_b;
        logic       ext_op;
        logic [2:0] alu_ctr;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } ctrl_t;

    // Quiescent control word: no strobes, muxes at 0, ALU left on add.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c         = '0;
        c.alu_ctr = ALU_ADD;
        return c;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Unified instruction/data memory handshake between the controller and memory.
interface mc_ctrl_if;
    logic mem_req;
    logic IorD;
    logic MemWr;
    logic mem_rdy;

    modport master (output mem_req, IorD, MemWr, input mem_rdy);
    modport slave  (input mem_req, IorD, MemWr, output mem_rdy);
endinterface

// File: rtl/mc_alu_dec.sv
// ALU control decode: maps state + op/funct to ALUctr/ExtOp and flags
// instructions the core does not implement.
module mc_alu_dec
    import mc_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctr_o,
    output logic       ext_op_o,
    output logic       legal_o
);

    logic [2:0] fn_ctr;
    logic       fn_ok;

    always_comb begin
        fn_ctr = ALU_ADD;
        fn_ok  = 1'b1;
        case (funct_i)
            FN_ADDU: fn_ctr = ALU_ADD;
            FN_SUBU: fn_ctr = ALU_SUB;
            FN_AND:  fn_ctr = ALU_AND;
            FN_OR:   fn_ctr = ALU_OR;
            FN_XOR:  fn_ctr = ALU_XOR;
            FN_SLT:  fn_ctr = ALU_SLT;
            default: fn_ok  = 1'b0;
        endcase
    end

    always_comb begin
        case (op_i)
            OP_RTYPE:                     legal_o = fn_ok;
            OP_ADDIU, OP_ORI, OP_LUI,
            OP_LW, OP_SW, OP_BEQ, OP_J:   legal_o = 1'b1;
            default:                      legal_o = 1'b0;
        endcase
    end

    always_comb begin
        alu_ctr_o = ALU_ADD;
        ext_op_o  = 1'b0;
        case (state_i)
            S_DECODE, S_MEM_ADR: ext_op_o = 1'b1;
            S_EXE_R:             alu_ctr_o = fn_ctr;
            S_EXE_I: begin
                case (op_i)
                    OP_ADDIU: ext_op_o  = 1'b1;
                    OP_ORI:   alu_ctr_o = ALU_OR;
                    OP_LUI:   alu_ctr_o = ALU_LUI;
                    default:  alu_ctr_o = ALU_ADD;
                endcase
            end
            S_BRANCH:            alu_ctr_o = ALU_SUB;
            default:             alu_ctr_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives the datapath controls and counts retired instructions.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    mc_ctrl_if.master        mem,
    output logic             IRWr,
    output logic             PCWr,
    output logic             PCWrCond,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ExtOp,
    output logic [2:0]       ALUctr,
    output logic             RegWr,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic [2:0]       dec_alu;
    logic             dec_ext;
    logic             legal;
    ctrl_t            c, c_out;

    // The datapath gates PC on zero via PCWrCond; the controller never needs it.
    logic unused_zero;
    assign unused_zero = zero;

    mc_alu_dec u_alu_dec (
        .state_i   (state_q),
        .op_i      (op),
        .funct_i   (funct),
        .alu_ctr_o (dec_alu),
        .ext_op_o  (dec_ext),
        .legal_o   (legal)
    );

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  if (mem.mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                if (!legal) begin
                    state_d = S_FETCH;
                end else begin
                    case (op)
                        OP_RTYPE:                 state_d = S_EXE_R;
                        OP_ADDIU, OP_ORI, OP_LUI: state_d = S_EXE_I;
                        OP_LW, OP_SW:             state_d = S_MEM_ADR;
                        OP_BEQ:                   state_d = S_BRANCH;
                        OP_J:                     state_d = S_JUMP;
                        default:                  state_d = S_FETCH;
                    endcase
                end
            end
            S_EXE_R, S_EXE_I: state_d = S_WB_ALU;
            S_MEM_ADR:        state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:         if (mem.mem_rdy) state_d = S_WB_MEM;
            S_MEM_WR: begin
                if (mem.mem_rdy) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        retired_d = retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        c         = ctrl_idle();
        c.alu_ctr = dec_alu;
        c.ext_op  = dec_ext;
        case (state_q)
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.src_b   = SRCB_FOUR;
                c.pc_src  = PCSRC_ALU;
                c.ir_wr   = mem.mem_rdy;
                c.pc_wr   = mem.mem_rdy;
            end
            S_DECODE: begin
                c.src_b   = SRCB_IMM_SH;
                c.illegal = !legal;
            end
            S_EXE_R: begin
                c.src_a = 1'b1;
                c.src_b = SRCB_REGB;
            end
            S_EXE_I, S_MEM_ADR: begin
                c.src_a = 1'b1;
                c.src_b = SRCB_IMM;
            end
            S_WB_ALU: begin
                c.reg_wr  = 1'b1;
                c.reg_dst = (op == OP_RTYPE);
            end
            S_MEM_RD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                c.mem_wr  = 1'b1;
            end
            S_WB_MEM: begin
                c.reg_wr     = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                c.src_a      = 1'b1;
                c.src_b      = SRCB_REGB;
                c.pc_wr_cond = 1'b1;
                c.pc_src     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                c.pc_wr  = 1'b1;
                c.pc_src = PCSRC_JUMP;
            end
            default: c = ctrl_idle();
        endcase
        // Reset must suppress writes from whatever state the FSM was in.
        c_out = rst ? ctrl_idle() : c;
    end

    assign mem.mem_req = c_out.mem_req;
    assign mem.IorD    = c_out.iord;
    assign mem.MemWr   = c_out.mem_wr;
    assign IRWr        = c_out.ir_wr;
    assign PCWr        = c_out.pc_wr;
    assign PCWrCond    = c_out.pc_wr_cond;
    assign PCSrc       = c_out.pc_src;
    assign ALUSrcA     = c_out.src_a;
    assign ALUSrcB     = c_out.src_b;
    assign ExtOp       = c_out.ext_op;
    assign ALUctr      = c_out.alu_ctr;
    assign RegWr       = c_out.reg_wr;
    assign RegDst      = c_out.reg_dst;
    assign MemtoReg    = c_out.mem_to_reg;
    assign illegal     = c_out.illegal;
    assign retired     = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction expected control sequences built from the
// instruction semantics, compared every cycle, plus a few literal anchors.
module tb_mc_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic       mem_req;
        logic       IorD;
        logic       MemWr;
        logic       IRWr;
        logic       PCWr;
        logic       PCWrCond;
        logic [1:0] PCSrc;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic       ExtOp;
        logic [2:0] ALUctr;
        logic       RegWr;
        logic       RegDst;
        logic       MemtoReg;
        logic       illegal;
    } outs_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    op, funct;
    logic          zero;
    logic          IRWr, PCWr, PCWrCond, ALUSrcA, ExtOp, RegWr, RegDst, MemtoReg, illegal;
    logic [1:0]    PCSrc, ALUSrcB;
    logic [2:0]    ALUctr;
    logic [CW-1:0] retired;

    mc_ctrl_if mem_if ();

    mc_ctrl #(.CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .mem      (mem_if),
        .IRWr     (IRWr),
        .PCWr     (PCWr),
        .PCWrCond (PCWrCond),
        .PCSrc    (PCSrc),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ExtOp    (ExtOp),
        .ALUctr   (ALUctr),
        .RegWr    (RegWr),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .illegal  (illegal),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    outs_t         act, exp_o;
    logic [CW-1:0] exp_ret;
    bit            exp_v = 1'b0;
    string         exp_tag;
    int            checks = 0;
    int            errors = 0;
    int            mcnt   = 0;
    int            ncyc   = 0;

    assign act = {mem_if.mem_req, mem_if.IorD, mem_if.MemWr, IRWr, PCWr, PCWrCond, PCSrc,
                  ALUSrcA, ALUSrcB, ExtOp, ALUctr, RegWr, RegDst, MemtoReg, illegal};

    always @(negedge clk) begin
        if (exp_v) begin
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("FAIL outs[%s] t=%0t act=%h exp=%h", exp_tag, $time, act, exp_o);
            end
            checks++;
            if (retired !== exp_ret) begin
                errors++;
                $display("FAIL retired[%s] t=%0t act=%0d exp=%0d", exp_tag, $time, retired, exp_ret);
            end
        end
    end

    function automatic outs_t idle();
        outs_t o = '0;
        o.ALUctr = 3'b001;
        return o;
    endfunction

    function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00: return (f == 6'h21 || f == 6'h23 || f == 6'h24 ||
                           f == 6'h25 || f == 6'h26 || f == 6'h2a);
            6'h09, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] fn_alu(input logic [5:0] f);
        case (f)
            6'h23:   return 3'b010;
            6'h24:   return 3'b011;
            6'h25:   return 3'b100;
            6'h26:   return 3'b101;
            6'h2a:   return 3'b111;
            default: return 3'b001;
        endcase
    endfunction

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic cyc(input string tag, input bit r, input int rdy, input outs_t e, input bit ret);
        rst            = r;
        mem_if.mem_rdy = rdy[0];
        zero           = 1'($urandom_range(1));
        exp_o          = e;
        exp_ret        = CW'(mcnt);
        exp_tag        = tag;
        exp_v          = 1'b1;
        @(posedge clk);
        #1;
        ncyc++;
        if (ret) mcnt = (mcnt + 1) % (1 << CW);
        if (r)   mcnt = 0;
    endtask

    task automatic run(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw,
                       input bit abort);
        outs_t e;
        bit    rt = (o == 6'h00);
        ncyc  = 0;
        op    = o;
        funct = f;
        e = idle(); e.mem_req = 1; e.ALUSrcB = 2'b01;
        repeat (fw) cyc("FETCH_WAIT", 0, 0, e, 0);
        e.IRWr = 1; e.PCWr = 1;
        cyc("FETCH", 0, 1, e, 0);
        e = idle(); e.ALUSrcB = 2'b11; e.ExtOp = 1; e.illegal = !is_legal(o, f);
        cyc("DECODE", 0, $urandom_range(1), e, 0);
        if (!is_legal(o, f)) return;
        case (o)
            6'h00, 6'h09, 6'h0d, 6'h0f: begin
                e = idle(); e.ALUSrcA = 1;
                if (rt) begin
                    e.ALUctr = fn_alu(f);
                end else begin
                    e.ALUSrcB = 2'b10;
                    e.ExtOp   = (o == 6'h09);
                    e.ALUctr  = (o == 6'h0d) ? 3'b100 : (o == 6'h0f) ? 3'b110 : 3'b001;
                end
                cyc("EXEC", 0, $urandom_range(1), e, 0);
                e = idle(); e.RegWr = 1; e.RegDst = rt;
                cyc("WB_ALU", 0, $urandom_range(1), e, 1);
            end
            6'h23, 6'h2b: begin
                e = idle(); e.ALUSrcA = 1; e.ALUSrcB = 2'b10; e.ExtOp = 1;
                cyc("MEM_ADR", 0, $urandom_range(1), e, 0);
                e = idle(); e.mem_req = 1; e.IorD = 1; e.MemWr = (o == 6'h2b);
                repeat (mw) cyc("MEM_WAIT", 0, 0, e, 0);
                if (abort) begin
                    cyc("RST_MID", 1, 1, idle(), 0);
                    return;
                end
                cyc("MEM", 0, 1, e, o == 6'h2b);
                if (o == 6'h23) begin
                    e = idle(); e.RegWr = 1; e.MemtoReg = 1;
                    cyc("WB_MEM", 0, $urandom_range(1), e, 1);
                end
            end
            6'h04: begin
                e = idle(); e.ALUSrcA = 1; e.ALUctr = 3'b010; e.PCWrCond = 1; e.PCSrc = 2'b01;
                cyc("BRANCH", 0, $urandom_range(1), e, 1);
            end
            default: begin
                e = idle(); e.PCWr = 1; e.PCSrc = 2'b10;
                cyc("JUMP", 0, $urandom_range(1), e, 1);
            end
        endcase
    endtask

    task automatic chk(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, a, e);
        end
    endtask

    logic [5:0] ops_t [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h09,
                               6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02};
    logic [5:0] fns_t [6]  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2a};

    initial begin
        rst = 1; op = 0; funct = 0; zero = 0; mem_if.mem_rdy = 1;
        @(posedge clk); #1;
        cyc("RST", 1, 1, idle(), 0);

        run(6'h00, 6'h21, 0, 0, 0); chk("addu_cycles", ncyc, 4); chk("addu_retired", int'(retired), 1);
        run(6'h00, 6'h2a, 0, 0, 0); chk("slt_cycles", ncyc, 4);
        run(6'h0f, 6'h00, 0, 0, 0); chk("lui_cycles", ncyc, 4);
        run(6'h23, 6'h00, 0, 2, 0); chk("lw_wait_cycles", ncyc, 7);
        run(6'h04, 6'h00, 0, 0, 0); chk("beq_cycles", ncyc, 3);
        run(6'h04, 6'h00, 0, 0, 0); chk("beq2_retired", int'(retired), 6);
        run(6'h3f, 6'h00, 0, 0, 0); chk("illegal_cycles", ncyc, 2); chk("illegal_retired", int'(retired), 6);
        run(6'h00, 6'h00, 0, 0, 0); chk("badfunct_cycles", ncyc, 2);
        run(6'h2b, 6'h00, 0, 0, 0); chk("sw_cycles", ncyc, 4);
        run(6'h02, 6'h00, 1, 0, 0); chk("j_fetchwait_cycles", ncyc, 4); chk("j_retired", int'(retired), 8);
        run(6'h2b, 6'h00, 0, 1, 1); chk("rst_mid_retired", int'(retired), 0);
        run(6'h00, 6'h21, 0, 0, 0); chk("after_rst_retired", int'(retired), 1);

        for (int n = 0; n < 300; n++) begin
            int         k = $urandom_range(14);
            logic [5:0] o, f;
            if (k < 13) begin
                o = ops_t[k];
                f = (o == 6'h00) ? fns_t[$urandom_range(5)] : 6'($urandom);
            end else if (k == 13) begin
                o = 6'h00; f = 6'h3f;
            end else begin
                o = 6'h3e; f = 6'($urandom);
            end
            run(o, f, $urandom_range(2), $urandom_range(2), 0);
        end

        exp_v = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
